axi_burst_selftest_master: RTL and testbench
============================================

# axi_burst_selftest_master

AXI4 full master that performs a single hardware self-test against an AXI4 full memory slave: one INCR write burst of a known pattern, then a read-back burst from the same address, with beat-by-beat comparison. It sits directly upstream of the slave and drives its S_AXI port. It gives the design a power-on or on-demand memory check without a processor. DONE, ERROR and ERR_COUNT are exported for status LEDs or a register block.

## Interface
Parameters:
- C_M_TARGET_BASE_ADDR, 32'h0000_0000: burst start address; must be 4 KB-boundary safe for the full burst.
- C_M_AXI_BURST_LEN, 8: beats per burst, range 1..256; AxLEN = C_M_AXI_BURST_LEN-1.
- C_M_AXI_ID_WIDTH, 1: ID width; all IDs are driven 0.
- C_M_AXI_ADDR_WIDTH, 32: address width.
- C_M_AXI_DATA_WIDTH, 32: data width; AxSIZE = clog2(C_M_AXI_DATA_WIDTH/8).
- C_DATA_SEED, 1: value written on beat 0.

Ports (one clock; reset is synchronous and active-high):
- ACLK  in  1  sole clock; everything samples on the rising edge.
- ARESET  in  1  synchronous, active-high reset.
- START  in  1  starts a test; acted on only in IDLE.
- BUSY  out  1  high in every state except IDLE and DONE.
- DONE  out  1  high in DONE; held until the next accepted START.
- ERROR  out  1  sticky error flag for the current test.
- ERR_COUNT  out  4  count of data-mismatch beats, saturating at 15.
- M_AXI_AW{ID,ADDR,LEN,SIZE,BURST,VALID}  out  per params  write address; BURST = INCR.
- M_AXI_AWREADY  in  1  write address ready.
- M_AXI_W{DATA,STRB,LAST,VALID}  out  per params  write data; WSTRB all ones.
- M_AXI_WREADY  in  1  write data ready.
- M_AXI_B{ID,RESP,VALID}  in  per params  write response.
- M_AXI_BREADY  out  1  write response ready.
- M_AXI_AR{ID,ADDR,LEN,SIZE,BURST,VALID}  out  per params  read address; BURST = INCR.
- M_AXI_ARREADY  in  1  read address ready.
- M_AXI_R{ID,DATA,RESP,LAST,VALID}  in  per params  read data.
- M_AXI_RREADY  out  1  read data ready.
- M_AXI_{AW,AR}{LOCK,CACHE,PROT,QOS}  out  per AXI4  constants, all 0.

## Operation
States: IDLE, WRITE, WAIT_B, RD_ADDR, READ, DONE.
- **IDLE / DONE:** START=1 moves to WRITE, clears ERROR, ERR_COUNT and the beat counters, and drops DONE. START in any other state is ignored.
- **WRITE:**
  - AWVALID and WVALID are both asserted on entry; the AW and W channels are independent.
  - AWVALID drops after its handshake.
  - WDATA = C_DATA_SEED + beat index, truncated to data width.
  - WLAST=1 only on beat C_M_AXI_BURST_LEN-1.
  - After the last W handshake and the AW handshake (either order), go to WAIT_B.
- **WAIT_B:** BREADY=1. When BVALID: BRESP≠OKAY sets ERROR. Then go to RD_ADDR.
- **RD_ADDR:** ARVALID=1 until its handshake, then go to READ.
- **READ:**
  - RREADY=1.
  - Each R handshake compares RDATA with C_DATA_SEED + read beat index.
  - A mismatch increments ERR_COUNT (saturating) and sets ERROR.
  - RRESP≠OKAY sets ERROR.
  - RLAST on any beat other than the last, or missing on the last beat, sets ERROR.
  - Exit to DONE on the last-index beat or on the first RLAST, whichever comes first.
- ERROR is the OR of all the above conditions; it is never cleared except by START or ARESET.

## Timing
- Reset values: all VALID/READY outputs 0, BUSY 0, DONE 0, ERROR 0, ERR_COUNT 0, state IDLE. Address/len/size/burst outputs hold their constant values.
- Reset mid-operation: IDLE on the next edge, with all VALIDs low. The downstream slave shares ARESET, so no outstanding transaction survives.
- START is sampled at edge N. AWVALID=1 and WVALID=1 from edge N+1.
- VALID rule: once VALID is high, it and its payload stay stable until the matching READY is seen at a rising edge. VALID never depends combinationally on READY.
- With an always-ready slave and a 1-cycle B/R latency, one test takes about 2×C_M_AXI_BURST_LEN + 6 cycles.
- W beat counter and R beat counter are separate and width clog2(C_M_AXI_BURST_LEN)+1. Neither wraps within a test.
- Comparison result is registered. ERR_COUNT and ERROR update on the edge after the R handshake. DONE rises on that same edge for the final beat.

## Test plan
- **Basic pass:** VIP slave always ready, memory model, START pulse. Expect:
  - AW at 0x0, LEN 7, SIZE 2, INCR.
  - WDATA 1..8, WLAST only on beat 7.
  - Read returns 1..8; DONE=1, ERROR=0, ERR_COUNT=0.
- **Backpressure:** AWREADY delayed 5 cycles, and WREADY/RREADY-side VALID gated on alternating cycles. Expect VALID and payload held stable, same data sequence, DONE=1, ERROR=0.
- **Data corruption:** slave returns 0xDEAD on read beat 3. Expect ERR_COUNT=1, ERROR=1, DONE=1.
- **Error response:** BRESP=SLVERR. Expect the read still performed and ERROR=1 at DONE with ERR_COUNT=0. RLAST asserted on beat 5 gives ERROR=1, DONE after beat 5.
- **START while busy:** START pulses during WRITE and READ. Expect them ignored and a single test run. A START after DONE clears flags and reruns.
- **Reset mid-burst:** ARESET asserted after W beat 4. Expect all VALIDs 0 and BUSY 0 on the next edge, state IDLE. A subsequent START gives a clean pass.

Source files
------------

// File: rtl/axi_burst_selftest_master_if.sv
// AXI4 full master-side bus bundle for the burst self-test master.
// Carries the five AXI channels; clock and reset stay outside.
interface axi_burst_selftest_master_if #(
    parameter int unsigned C_M_AXI_ID_WIDTH   = 1,
    parameter int unsigned C_M_AXI_ADDR_WIDTH = 32,
    parameter int unsigned C_M_AXI_DATA_WIDTH = 32
);
    logic [C_M_AXI_ID_WIDTH-1:0]     awid;
    logic [C_M_AXI_ADDR_WIDTH-1:0]   awaddr;
    logic [7:0]                      awlen;
    logic [2:0]                      awsize;
    logic [1:0]                      awburst;
    logic                            awlock;
    logic [3:0]                      awcache;
    logic [2:0]                      awprot;
    logic [3:0]                      awqos;
    logic                            awvalid;
    logic                            awready;

    logic [C_M_AXI_DATA_WIDTH-1:0]   wdata;
    logic [C_M_AXI_DATA_WIDTH/8-1:0] wstrb;
    logic                            wlast;
    logic                            wvalid;
    logic                            wready;

    logic [C_M_AXI_ID_WIDTH-1:0]     bid;
    logic [1:0]                      bresp;
    logic                            bvalid;
    logic                            bready;

    logic [C_M_AXI_ID_WIDTH-1:0]     arid;
    logic [C_M_AXI_ADDR_WIDTH-1:0]   araddr;
    logic [7:0]                      arlen;
    logic [2:0]                      arsize;
    logic [1:0]                      arburst;
    logic                            arlock;
    logic [3:0]                      arcache;
    logic [2:0]                      arprot;
    logic [3:0]                      arqos;
    logic                            arvalid;
    logic                            arready;

    logic [C_M_AXI_ID_WIDTH-1:0]     rid;
    logic [C_M_AXI_DATA_WIDTH-1:0]   rdata;
    logic [1:0]                      rresp;
    logic                            rlast;
    logic                            rvalid;
    logic                            rready;

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready,
        output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready
    );

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready,
        input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready
    );
endinterface

// File: rtl/axi_burst_selftest_master.sv
// AXI4 memory self-test: one INCR write burst of seed+index data, then a read-back
// burst from the same address with per-beat comparison and sticky error reporting.
module axi_burst_selftest_master #(
    parameter int unsigned                   C_M_AXI_ID_WIDTH     = 1,
    parameter int unsigned                   C_M_AXI_ADDR_WIDTH   = 32,
    parameter int unsigned                   C_M_AXI_DATA_WIDTH   = 32,
    parameter logic [C_M_AXI_ADDR_WIDTH-1:0] C_M_TARGET_BASE_ADDR = '0,
    parameter int unsigned                   C_M_AXI_BURST_LEN    = 8,
    parameter int unsigned                   C_DATA_SEED          = 1
) (
    input  logic                       ACLK,
    input  logic                       ARESET,
    input  logic                       START,
    output logic                       BUSY,
    output logic                       DONE,
    output logic                       ERROR,
    output logic [3:0]                 ERR_COUNT,
    axi_burst_selftest_master_if.master m_axi
);

    localparam int unsigned DW   = C_M_AXI_DATA_WIDTH;
    localparam int unsigned CntW = $clog2(C_M_AXI_BURST_LEN) + 1;

    localparam logic [CntW-1:0] LastIdx = CntW'(C_M_AXI_BURST_LEN - 1);
    localparam logic [7:0]      AxLen   = 8'(C_M_AXI_BURST_LEN - 1);
    localparam logic [2:0]      AxSize  = 3'($clog2(C_M_AXI_DATA_WIDTH / 8));
    localparam logic [1:0]      BurstIncr = 2'b01;
    localparam logic [1:0]      RespOkay  = 2'b00;

    typedef enum logic [2:0] {
        StIdle,
        StWrite,
        StWaitB,
        StRdAddr,
        StRead,
        StDone
    } state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] w_cnt_q, w_cnt_d;
    logic [CntW-1:0] r_cnt_q, r_cnt_d;
    logic            aw_done_q, aw_done_d;
    logic            w_done_q, w_done_d;
    logic            error_q, error_d;
    logic [3:0]      err_count_q, err_count_d;

    logic            aw_valid, w_valid, w_last;
    logic            aw_hs, w_hs;
    logic            r_is_last;
    logic [DW-1:0]   w_data, exp_rdata;

    // Valids come only from state and done flags, never from the matching ready.
    assign aw_valid  = (state_q == StWrite) && !aw_done_q;
    assign w_valid   = (state_q == StWrite) && !w_done_q;
    assign w_last    = (w_cnt_q == LastIdx);
    assign aw_hs     = aw_valid && m_axi.awready;
    assign w_hs      = w_valid && m_axi.wready;
    assign r_is_last = (r_cnt_q == LastIdx);
    assign w_data    = DW'(C_DATA_SEED) + DW'(w_cnt_q);
    assign exp_rdata = DW'(C_DATA_SEED) + DW'(r_cnt_q);

    always_comb begin
        state_d     = state_q;
        w_cnt_d     = w_cnt_q;
        r_cnt_d     = r_cnt_q;
        aw_done_d   = aw_done_q;
        w_done_d    = w_done_q;
        error_d     = error_q;
        err_count_d = err_count_q;

        unique case (state_q)
            StIdle, StDone: begin
                if (START) begin
                    state_d     = StWrite;
                    w_cnt_d     = '0;
                    r_cnt_d     = '0;
                    aw_done_d   = 1'b0;
                    w_done_d    = 1'b0;
                    error_d     = 1'b0;
                    err_count_d = 4'd0;
                end
            end
            StWrite: begin
                if (aw_hs) begin
                    aw_done_d = 1'b1;
                end
                if (w_hs) begin
                    w_cnt_d = w_cnt_q + CntW'(1);
                    if (w_last) begin
                        w_done_d = 1'b1;
                    end
                end
                // AW and W may finish in either order, or on the same edge.
                if ((aw_done_q || aw_hs) && (w_done_q || (w_hs && w_last))) begin
                    state_d = StWaitB;
                end
            end
            StWaitB: begin
                if (m_axi.bvalid) begin
                    if (m_axi.bresp != RespOkay) begin
                        error_d = 1'b1;
                    end
                    state_d = StRdAddr;
                end
            end
            StRdAddr: begin
                if (m_axi.arready) begin
                    state_d = StRead;
                end
            end
            StRead: begin
                if (m_axi.rvalid) begin
                    r_cnt_d = r_cnt_q + CntW'(1);
                    if (m_axi.rdata != exp_rdata) begin
                        error_d = 1'b1;
                        if (err_count_q != 4'hF) begin
                            err_count_d = err_count_q + 4'd1;
                        end
                    end
                    if (m_axi.rresp != RespOkay) begin
                        error_d = 1'b1;
                    end
                    if (m_axi.rlast != r_is_last) begin
                        error_d = 1'b1;
                    end
                    if (r_is_last || m_axi.rlast) begin
                        state_d = StDone;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q     <= StIdle;
            w_cnt_q     <= '0;
            r_cnt_q     <= '0;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            error_q     <= 1'b0;
            err_count_q <= 4'd0;
        end else begin
            state_q     <= state_d;
            w_cnt_q     <= w_cnt_d;
            r_cnt_q     <= r_cnt_d;
            aw_done_q   <= aw_done_d;
            w_done_q    <= w_done_d;
            error_q     <= error_d;
            err_count_q <= err_count_d;
        end
    end

    assign BUSY      = (state_q != StIdle) && (state_q != StDone);
    assign DONE      = (state_q == StDone);
    assign ERROR     = error_q;
    assign ERR_COUNT = err_count_q;

    assign m_axi.awid    = '0;
    assign m_axi.awaddr  = C_M_TARGET_BASE_ADDR;
    assign m_axi.awlen   = AxLen;
    assign m_axi.awsize  = AxSize;
    assign m_axi.awburst = BurstIncr;
    assign m_axi.awlock  = 1'b0;
    assign m_axi.awcache = 4'd0;
    assign m_axi.awprot  = 3'd0;
    assign m_axi.awqos   = 4'd0;
    assign m_axi.awvalid = aw_valid;

    assign m_axi.wdata  = w_data;
    assign m_axi.wstrb  = '1;
    assign m_axi.wlast  = w_last;
    assign m_axi.wvalid = w_valid;

    assign m_axi.bready = (state_q == StWaitB);

    assign m_axi.arid    = '0;
    assign m_axi.araddr  = C_M_TARGET_BASE_ADDR;
    assign m_axi.arlen   = AxLen;
    assign m_axi.arsize  = AxSize;
    assign m_axi.arburst = BurstIncr;
    assign m_axi.arlock  = 1'b0;
    assign m_axi.arcache = 4'd0;
    assign m_axi.arprot  = 3'd0;
    assign m_axi.arqos   = 4'd0;
    assign m_axi.arvalid = (state_q == StRdAddr);

    assign m_axi.rready = (state_q == StRead);

    // Response IDs carry no information since every request uses ID 0.
    logic unused_ids;
    assign unused_ids = ^{m_axi.bid, m_axi.rid};

endmodule

// File: tb/tb_axi_burst_selftest_master.sv
// Bench for axi_burst_selftest_master: reactive AXI memory slave with configurable
// backpressure and fault injection, checked against a per-test outcome model.
module tb_axi_burst_selftest_master;

    localparam int unsigned LEN  = 8;
    localparam int unsigned SEED = 1;
    localparam logic [31:0] BASE = 32'h0000_0000;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       busy, done, error;
    logic [3:0] err_count;

    always #5 clk = ~clk;

    axi_burst_selftest_master_if #(
        .C_M_AXI_ID_WIDTH   (1),
        .C_M_AXI_ADDR_WIDTH (32),
        .C_M_AXI_DATA_WIDTH (32)
    ) bus ();

    axi_burst_selftest_master #(
        .C_M_AXI_ID_WIDTH     (1),
        .C_M_AXI_ADDR_WIDTH   (32),
        .C_M_AXI_DATA_WIDTH   (32),
        .C_M_TARGET_BASE_ADDR (BASE),
        .C_M_AXI_BURST_LEN    (LEN),
        .C_DATA_SEED          (SEED)
    ) dut (
        .ACLK      (clk),
        .ARESET    (rst),
        .START     (start),
        .BUSY      (busy),
        .DONE      (done),
        .ERROR     (error),
        .ERR_COUNT (err_count),
        .m_axi     (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Slave configuration
    int         cfg_aw_delay, cfg_w_pct, cfg_r_pct, cfg_ar_pct;
    bit         cfg_alt;
    logic [1:0] cfg_bresp;
    bit         cfg_corrupt[LEN];
    logic [1:0] cfg_rresp[LEN];
    int         cfg_early_last;
    bit         cfg_drop_last;

    // Slave state and observations
    int          aw_wait, r_idx, cyc;
    bit          aw_got, w_last_got, b_pend, b_issued, ar_got, r_stop;
    logic [31:0] mem[LEN];
    logic [31:0] cap_awaddr, cap_araddr;
    logic [7:0]  cap_awlen, cap_arlen;
    logic [2:0]  cap_awsize, cap_arsize;
    logic [1:0]  cap_awburst, cap_arburst;
    logic [31:0] q_wdata[$];
    bit          q_wlast[$];
    int          n_aw, n_ar, n_b, r_beats, stab_viol, strb_bad;
    bit          p_aw, p_w, p_ar, p_wlast;
    logic [31:0] p_awaddr, p_wdata, p_araddr;

    task automatic reset_slave();
        aw_wait = 0; aw_got = 0; w_last_got = 0; b_pend = 0; b_issued = 0;
        ar_got = 0; r_stop = 0; r_idx = 0;
        p_aw = 0; p_w = 0; p_ar = 0;
        q_wdata.delete(); q_wlast.delete();
        n_aw = 0; n_ar = 0; n_b = 0; r_beats = 0; stab_viol = 0; strb_bad = 0;
    endtask

    task automatic cfg_clean();
        cfg_aw_delay = 0; cfg_w_pct = 100; cfg_r_pct = 100; cfg_ar_pct = 100; cfg_alt = 0;
        cfg_bresp = 2'b00; cfg_early_last = -1; cfg_drop_last = 0;
        for (int i = 0; i < LEN; i++) begin
            cfg_corrupt[i] = 0;
            cfg_rresp[i]   = 2'b00;
        end
    endtask

    // Expected outcome of one test from the slave configuration alone.
    function automatic void ref_model(output bit e_err, output int e_cnt, output int e_beats);
        int mism = 0;
        e_beats = (cfg_early_last >= 0 && cfg_early_last < LEN - 1) ? cfg_early_last + 1 : LEN;
        e_err   = (cfg_bresp != 2'b00) || (e_beats != LEN) || (e_beats == LEN && cfg_drop_last);
        for (int i = 0; i < e_beats; i++) begin
            if (cfg_corrupt[i] && 32'hDEAD != 32'(SEED + i)) mism++;
            if (cfg_rresp[i] != 2'b00) e_err = 1;
        end
        if (mism > 0) e_err = 1;
        e_cnt = (mism > 15) ? 15 : mism;
    endfunction

    // Slave: drive at negedge, then observe the handshakes that the next posedge completes.
    initial begin
        bus.awready = 0; bus.wready = 0; bus.bvalid = 0; bus.bresp = 0; bus.bid = '0;
        bus.arready = 0; bus.rvalid = 0; bus.rdata = '0; bus.rresp = 0; bus.rlast = 0;
        bus.rid = '0;
        cyc = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                reset_slave();
                bus.awready = 0; bus.wready = 0; bus.bvalid = 0; bus.arready = 0;
                bus.rvalid = 0; bus.rlast = 0;
            end else begin
                cyc++;
                bus.awready = bus.awvalid && (aw_wait >= cfg_aw_delay);
                bus.wready  = cfg_alt ? ((cyc % 2) == 1) : ($urandom_range(99) < cfg_w_pct);
                bus.bvalid  = b_pend;
                bus.bresp   = cfg_bresp;
                bus.arready = ($urandom_range(99) < cfg_ar_pct);
                if (ar_got && !r_stop && r_idx < LEN) begin
                    bus.rvalid = cfg_alt ? ((cyc % 2) == 0) : ($urandom_range(99) < cfg_r_pct);
                    bus.rdata  = cfg_corrupt[r_idx] ? 32'hDEAD : mem[r_idx];
                    bus.rresp  = cfg_rresp[r_idx];
                    bus.rlast  = (r_idx == cfg_early_last) || (r_idx == LEN - 1 && !cfg_drop_last);
                end else begin
                    bus.rvalid = 0; bus.rlast = 0; bus.rdata = '0; bus.rresp = 0;
                end
                #1;
                if (p_aw && (bus.awvalid !== 1'b1 || bus.awaddr !== p_awaddr)) stab_viol++;
                if (p_w && (bus.wvalid !== 1'b1 || bus.wdata !== p_wdata || bus.wlast !== p_wlast))
                    stab_viol++;
                if (p_ar && (bus.arvalid !== 1'b1 || bus.araddr !== p_araddr)) stab_viol++;
                p_aw = bus.awvalid && !bus.awready; p_awaddr = bus.awaddr;
                p_w  = bus.wvalid && !bus.wready;   p_wdata  = bus.wdata; p_wlast = bus.wlast;
                p_ar = bus.arvalid && !bus.arready; p_araddr = bus.araddr;
                if (bus.awvalid && !bus.awready) aw_wait++;
                if (bus.awvalid && bus.awready) begin
                    cap_awaddr = bus.awaddr; cap_awlen = bus.awlen; cap_awsize = bus.awsize;
                    cap_awburst = bus.awburst; aw_got = 1; n_aw++;
                end
                if (bus.wvalid && bus.wready) begin
                    if (q_wdata.size() < LEN) mem[q_wdata.size()] = bus.wdata;
                    if (bus.wstrb !== 4'hF) strb_bad++;
                    q_wdata.push_back(bus.wdata);
                    q_wlast.push_back(bus.wlast);
                    if (bus.wlast) w_last_got = 1;
                end
                if (bus.bvalid && bus.bready) begin
                    b_pend = 0; n_b++;
                end
                if (aw_got && w_last_got && !b_issued) begin
                    b_pend = 1; b_issued = 1;
                end
                if (bus.arvalid && bus.arready) begin
                    cap_araddr = bus.araddr; cap_arlen = bus.arlen; cap_arsize = bus.arsize;
                    cap_arburst = bus.arburst; ar_got = 1; n_ar++;
                end
                if (bus.rvalid && bus.rready) begin
                    r_beats++;
                    if (bus.rlast) r_stop = 1;
                    r_idx++;
                end
            end
        end
    end

    task automatic pulse_start();
        @(posedge clk); #2; start = 1;
        @(posedge clk); #2; start = 0;
    endtask

    task automatic wait_done(output int cycles, output bit to);
        cycles = 0; to = 0;
        while (!done) begin
            @(posedge clk); #1;
            cycles++;
            if (cycles > 400) begin to = 1; break; end
        end
    endtask

    task automatic test_reset();
        rst = 1; start = 0;
        repeat (3) @(posedge clk);
        #1;
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
        n_tests++; if (error !== 1'b0) begin n_fail++; $display("FAIL reset_error: got %b want 0", error); end
        n_tests++; if (err_count !== 4'd0) begin n_fail++; $display("FAIL reset_errcnt: got %0d want 0", err_count); end
        n_tests++;
        if ({bus.awvalid, bus.wvalid, bus.bready, bus.arvalid, bus.rready} !== 5'b0) begin
            n_fail++; $display("FAIL reset_valids: got %b want 00000",
                {bus.awvalid, bus.wvalid, bus.bready, bus.arvalid, bus.rready});
        end
        n_tests++;
        if ({bus.awlen, bus.awsize, bus.awburst} !== {8'd7, 3'd2, 2'b01}) begin
            n_fail++; $display("FAIL reset_awconst: got %0d/%0d/%0d want 7/2/1",
                bus.awlen, bus.awsize, bus.awburst);
        end
        n_tests++;
        if ({bus.awlock, bus.awcache, bus.awprot, bus.awqos, bus.arlock, bus.arcache, bus.arprot,
             bus.arqos, bus.awid, bus.arid} !== '0) begin
            n_fail++; $display("FAIL reset_sideband: got nonzero want 0");
        end
        #1 rst = 0;
    endtask

    task automatic test_basic_pass();
        int cycles; bit to; int bad;
        cfg_clean(); reset_slave();
        @(posedge clk); #2; start = 1;
        @(posedge clk); #1;
        n_tests++;
        if ({bus.awvalid, bus.wvalid, busy, done} !== 4'b1110) begin
            n_fail++; $display("FAIL start_latency: got %b want 1110",
                {bus.awvalid, bus.wvalid, busy, done});
        end
        #1 start = 0;
        wait_done(cycles, to);
        n_tests++; if (to) begin n_fail++; $display("FAIL basic_timeout: got %0d cycles want DONE", cycles); end
        n_tests++;
        if (cycles > 2 * LEN + 6) begin
            n_fail++; $display("FAIL basic_latency: got %0d want <= %0d", cycles, 2 * LEN + 6);
        end
        n_tests++;
        if ({cap_awaddr, cap_awlen, cap_awsize, cap_awburst} !== {BASE, 8'd7, 3'd2, 2'b01}) begin
            n_fail++; $display("FAIL basic_aw: got %h/%0d/%0d/%0d want 0/7/2/1",
                cap_awaddr, cap_awlen, cap_awsize, cap_awburst);
        end
        n_tests++;
        if ({cap_araddr, cap_arlen, cap_arsize, cap_arburst} !== {BASE, 8'd7, 3'd2, 2'b01}) begin
            n_fail++; $display("FAIL basic_ar: got %h/%0d/%0d/%0d want 0/7/2/1",
                cap_araddr, cap_arlen, cap_arsize, cap_arburst);
        end
        n_tests++;
        if (q_wdata.size() != LEN) begin
            n_fail++; $display("FAIL basic_wbeats: got %0d want %0d", q_wdata.size(), LEN);
        end
        bad = 0;
        for (int i = 0; i < q_wdata.size() && i < LEN; i++) begin
            if (q_wdata[i] !== 32'(SEED + i) || q_wlast[i] !== (i == LEN - 1)) bad++;
        end
        n_tests++; if (bad != 0) begin n_fail++; $display("FAIL basic_wdata: got %0d bad beats want 0", bad); end
        n_tests++; if (strb_bad != 0) begin n_fail++; $display("FAIL basic_wstrb: got %0d bad want 0", strb_bad); end
        n_tests++;
        if ({done, error, err_count} !== {1'b1, 1'b0, 4'd0}) begin
            n_fail++; $display("FAIL basic_status: got done=%b err=%b cnt=%0d want 1/0/0",
                done, error, err_count);
        end
        repeat (3) @(posedge clk);
        #1;
        n_tests++;
        if ({done, busy} !== 2'b10) begin
            n_fail++; $display("FAIL done_hold: got done=%b busy=%b want 1/0", done, busy);
        end
    endtask

    task automatic test_backpressure();
        int cycles; bit to; int bad;
        cfg_clean(); cfg_aw_delay = 5; cfg_alt = 1; cfg_ar_pct = 40;
        #1 reset_slave();
        pulse_start();
        wait_done(cycles, to);
        bad = 0;
        for (int i = 0; i < q_wdata.size() && i < LEN; i++) begin
            if (q_wdata[i] !== 32'(SEED + i) || q_wlast[i] !== (i == LEN - 1)) bad++;
        end
        n_tests++;
        if (to || q_wdata.size() != LEN || bad != 0) begin
            n_fail++; $display("FAIL bp_wdata: got to=%b beats=%0d bad=%0d want 0/%0d/0",
                to, q_wdata.size(), bad, LEN);
        end
        n_tests++; if (stab_viol != 0) begin n_fail++; $display("FAIL bp_stable: got %0d violations want 0", stab_viol); end
        n_tests++;
        if ({done, error, err_count} !== {1'b1, 1'b0, 4'd0}) begin
            n_fail++; $display("FAIL bp_status: got done=%b err=%b cnt=%0d want 1/0/0",
                done, error, err_count);
        end
    endtask

    task automatic test_corruption();
        int cycles; bit to;
        cfg_clean(); cfg_corrupt[3] = 1;
        #1 reset_slave();
        pulse_start();
        wait_done(cycles, to);
        n_tests++;
        if (to || {done, error, err_count} !== {1'b1, 1'b1, 4'd1}) begin
            n_fail++; $display("FAIL corrupt_status: got to=%b done=%b err=%b cnt=%0d want 0/1/1/1",
                to, done, error, err_count);
        end
    endtask

    task automatic test_error_resp();
        int cycles; bit to;
        cfg_clean(); cfg_bresp = 2'b10;
        #1 reset_slave();
        pulse_start();
        wait_done(cycles, to);
        n_tests++;
        if (to || n_ar != 1 || r_beats != LEN) begin
            n_fail++; $display("FAIL bresp_read: got to=%b ar=%0d beats=%0d want 0/1/%0d",
                to, n_ar, r_beats, LEN);
        end
        n_tests++;
        if ({done, error, err_count} !== {1'b1, 1'b1, 4'd0}) begin
            n_fail++; $display("FAIL bresp_status: got done=%b err=%b cnt=%0d want 1/1/0",
                done, error, err_count);
        end
        cfg_clean(); cfg_early_last = 5;
        #1 reset_slave();
        pulse_start();
        wait_done(cycles, to);
        n_tests++;
        if (to || r_beats != 6) begin
            n_fail++; $display("FAIL early_rlast_beats: got to=%b beats=%0d want 0/6", to, r_beats);
        end
        n_tests++;
        if ({done, error, err_count} !== {1'b1, 1'b1, 4'd0}) begin
            n_fail++; $display("FAIL early_rlast_status: got done=%b err=%b cnt=%0d want 1/1/0",
                done, error, err_count);
        end
    endtask

    task automatic test_start_while_busy();
        int cycles; bit to; int guard;
        cfg_clean(); cfg_alt = 1; cfg_corrupt[0] = 1;
        #1 reset_slave();
        pulse_start();
        guard = 0;
        while (q_wdata.size() < 2 && guard < 100) begin @(posedge clk); #1; guard++; end
        #1 start = 1;
        @(posedge clk); #2 start = 0;
        guard = 0;
        while (r_beats < 2 && guard < 100) begin @(posedge clk); #1; guard++; end
        #1 start = 1;
        @(posedge clk); #2 start = 0;
        wait_done(cycles, to);
        n_tests++;
        if (to || n_aw != 1 || n_ar != 1 || q_wdata.size() != LEN || r_beats != LEN) begin
            n_fail++; $display("FAIL busy_start_ignored: got to=%b aw=%0d ar=%0d w=%0d r=%0d want 0/1/1/%0d/%0d",
                to, n_aw, n_ar, q_wdata.size(), r_beats, LEN, LEN);
        end
        n_tests++;
        if ({error, err_count} !== {1'b1, 4'd1}) begin
            n_fail++; $display("FAIL busy_run_status: got err=%b cnt=%0d want 1/1", error, err_count);
        end
        cfg_clean();
        #1 reset_slave();
        @(posedge clk); #2 start = 1;
        @(posedge clk); #1;
        n_tests++;
        if ({done, error, err_count, busy} !== {1'b0, 1'b0, 4'd0, 1'b1}) begin
            n_fail++; $display("FAIL restart_clear: got done=%b err=%b cnt=%0d busy=%b want 0/0/0/1",
                done, error, err_count, busy);
        end
        #1 start = 0;
        wait_done(cycles, to);
        n_tests++;
        if (to || {done, error} !== 2'b10) begin
            n_fail++; $display("FAIL restart_pass: got to=%b done=%b err=%b want 0/1/0", to, done, error);
        end
    endtask

    task automatic test_reset_mid();
        int cycles; bit to; int guard; int bad;
        cfg_clean(); cfg_alt = 1;
        #1 reset_slave();
        pulse_start();
        guard = 0;
        while (q_wdata.size() < 5 && guard < 100) begin @(posedge clk); #1; guard++; end
        #1 rst = 1;
        @(posedge clk); #1;
        n_tests++;
        if ({bus.awvalid, bus.wvalid, bus.bready, bus.arvalid, bus.rready, busy, done} !== 7'b0) begin
            n_fail++; $display("FAIL midreset_idle: got %b want 0000000",
                {bus.awvalid, bus.wvalid, bus.bready, bus.arvalid, bus.rready, busy, done});
        end
        #1 rst = 0;
        cfg_clean();
        @(posedge clk); #2 reset_slave();
        pulse_start();
        wait_done(cycles, to);
        bad = 0;
        for (int i = 0; i < q_wdata.size() && i < LEN; i++) if (q_wdata[i] !== 32'(SEED + i)) bad++;
        n_tests++;
        if (to || q_wdata.size() != LEN || bad != 0 || {done, error, err_count} !== {1'b1, 1'b0, 4'd0}) begin
            n_fail++; $display("FAIL midreset_rerun: got to=%b w=%0d bad=%0d done=%b err=%b cnt=%0d want clean pass",
                to, q_wdata.size(), bad, done, error, err_count);
        end
    endtask

    task automatic test_random();
        int cycles; bit to; int bad; bit e_err; int e_cnt; int e_beats;
        for (int it = 0; it < 10; it++) begin
            cfg_clean();
            cfg_aw_delay = $urandom_range(4);
            cfg_w_pct    = $urandom_range(100, 30);
            cfg_r_pct    = $urandom_range(100, 30);
            cfg_ar_pct   = $urandom_range(100, 30);
            cfg_bresp    = ($urandom_range(3) == 0) ? 2'b10 : 2'b00;
            for (int i = 0; i < LEN; i++) begin
                cfg_corrupt[i] = ($urandom_range(4) == 0);
                cfg_rresp[i]   = ($urandom_range(9) == 0) ? 2'b10 : 2'b00;
            end
            if ($urandom_range(3) == 0) cfg_early_last = $urandom_range(LEN - 2);
            cfg_drop_last = ($urandom_range(4) == 0);
            ref_model(e_err, e_cnt, e_beats);
            #1 reset_slave();
            pulse_start();
            wait_done(cycles, to);
            bad = 0;
            for (int i = 0; i < q_wdata.size() && i < LEN; i++) begin
                if (q_wdata[i] !== 32'(SEED + i) || q_wlast[i] !== (i == LEN - 1)) bad++;
            end
            n_tests++;
            if (to || r_beats != e_beats || q_wdata.size() != LEN || bad != 0 || stab_viol != 0) begin
                n_fail++; $display("FAIL rand%0d_flow: got to=%b r=%0d w=%0d bad=%0d stab=%0d want 0/%0d/%0d/0/0",
                    it, to, r_beats, q_wdata.size(), bad, stab_viol, e_beats, LEN);
            end
            n_tests++;
            if ({done, error, err_count} !== {1'b1, e_err, 4'(e_cnt)}) begin
                n_fail++; $display("FAIL rand%0d_status: got done=%b err=%b cnt=%0d want 1/%b/%0d",
                    it, done, error, err_count, e_err, e_cnt);
            end
        end
    endtask

    initial begin
        rst = 1; start = 0;
        cfg_clean();
        test_reset();
        test_basic_pass();
        test_backpressure();
        test_corruption();
        test_error_resp();
        test_start_while_busy();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
